// File: rtl/core_sequencer_pkg.sv
// Shared constants for the multi-cycle RV32I sequencer: opcodes, state
// encodings, the reset NOP and the opcode-to-next-state decision.
package core_sequencer_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] SEQ_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        SEQ_ST_FETCH   = 3'd0,
        SEQ_ST_EXECUTE = 3'd1,
        SEQ_ST_MEM_RD  = 3'd2,
        SEQ_ST_MEM_WR  = 3'd3,
        SEQ_ST_COMMIT  = 3'd4,
        SEQ_ST_HALT    = 3'd5
    } seq_state_e;

    // Where an instruction goes after its decode cycle; unknown opcodes halt.
    function automatic seq_state_e seq_after_execute(input logic [6:0] opcode);
        case (opcode)
            OPC_LOAD:   return SEQ_ST_MEM_RD;
            OPC_STORE:  return SEQ_ST_MEM_WR;
            OPC_SYSTEM: return SEQ_ST_HALT;
            OPC_OP, OPC_OP_IMM, OPC_BRANCH, OPC_JAL,
            OPC_JALR, OPC_LUI, OPC_AUIPC: return SEQ_ST_COMMIT;
            default:    return SEQ_ST_HALT;
        endcase
    endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/execute/memory/commit sequencer around the combinational
// RV32I decode block; owns PC, instruction register and retire counter.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             nrst,
    output logic             imem_req_out,
    output logic [31:0]      imem_addr_out,
    input  logic             imem_ack_in,
    input  logic [31:0]      imem_data_in,
    output logic [31:0]      instr_out,
    output logic [31:0]      pc_out,
    input  logic [31:0]      pc_next_in,
    input  logic             reg_wr_en_in,
    output logic             reg_wr_en_out,
    output logic             dmem_req_out,
    output logic             dmem_we_out,
    input  logic             dmem_ack_in,
    input  logic [31:0]      dmem_rd_data_in,
    output logic [31:0]      dmem_rd_data_out,
    output logic             halted_out,
    output logic             error_out,
    output logic [CNT_W-1:0] retired_out
);

    seq_state_e       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      ld_q, ld_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             error_q, error_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= SEQ_ST_FETCH;
            pc_q      <= RESET_VECTOR;
            instr_q   <= SEQ_NOP;
            ld_q      <= '0;
            retired_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ld_q      <= ld_d;
            retired_q <= retired_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ld_d      = ld_q;
        retired_d = retired_q;
        error_d   = error_q;
        case (state_q)
            SEQ_ST_FETCH: begin
                if (imem_ack_in) begin
                    instr_d = imem_data_in;
                    state_d = SEQ_ST_EXECUTE;
                end
            end
            SEQ_ST_EXECUTE: begin
                state_d = seq_after_execute(instr_q[6:0]);
                if (instr_q[6:0] != OPC_SYSTEM && state_d == SEQ_ST_HALT) begin
                    error_d = 1'b1;
                end
            end
            SEQ_ST_MEM_RD: begin
                if (dmem_ack_in) begin
                    ld_d    = dmem_rd_data_in;
                    state_d = SEQ_ST_COMMIT;
                end
            end
            SEQ_ST_MEM_WR: begin
                if (dmem_ack_in) begin
                    state_d = SEQ_ST_COMMIT;
                end
            end
            SEQ_ST_COMMIT: begin
                // A misaligned target still retires; the fault is raised afterwards.
                pc_d      = pc_next_in;
                retired_d = retired_q + CNT_W'(1);
                if (pc_next_in[1:0] != 2'b00) begin
                    error_d = 1'b1;
                    state_d = SEQ_ST_HALT;
                end else begin
                    state_d = SEQ_ST_FETCH;
                end
            end
            SEQ_ST_HALT: state_d = SEQ_ST_HALT;
            default:     state_d = SEQ_ST_HALT;
        endcase
    end

    // Requests are qualified by nrst so an asserted reset drops them at once.
    assign imem_req_out     = nrst && (state_q == SEQ_ST_FETCH);
    assign imem_addr_out    = pc_q;
    assign dmem_req_out     = nrst && (state_q == SEQ_ST_MEM_RD || state_q == SEQ_ST_MEM_WR);
    assign dmem_we_out      = nrst && (state_q == SEQ_ST_MEM_WR);
    assign reg_wr_en_out    = nrst && (state_q == SEQ_ST_COMMIT) && reg_wr_en_in;
    assign instr_out        = instr_q;
    assign pc_out           = pc_q;
    assign dmem_rd_data_out = ld_q;
    assign halted_out       = (state_q == SEQ_ST_HALT);
    assign error_out        = error_q;
    assign retired_out      = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized scoreboard bench for core_sequencer: the stimulus side plays
// instruction/data memory and decode block, a monitor checks DUT outputs.
module tb_core_sequencer;

    localparam int          CNT_W = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             imem_req_out;
    logic [31:0]      imem_addr_out;
    logic             imem_ack_in = 1'b0;
    logic [31:0]      imem_data_in = '0;
    logic [31:0]      instr_out;
    logic [31:0]      pc_out;
    logic [31:0]      pc_next_in = '0;
    logic             reg_wr_en_in = 1'b0;
    logic             reg_wr_en_out;
    logic             dmem_req_out;
    logic             dmem_we_out;
    logic             dmem_ack_in = 1'b0;
    logic [31:0]      dmem_rd_data_in = '0;
    logic [31:0]      dmem_rd_data_out;
    logic             halted_out;
    logic             error_out;
    logic [CNT_W-1:0] retired_out;

    core_sequencer #(.RESET_VECTOR(RV), .CNT_W(CNT_W)) dut (
        .clk(clk), .nrst(nrst),
        .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
        .imem_ack_in(imem_ack_in), .imem_data_in(imem_data_in),
        .instr_out(instr_out), .pc_out(pc_out), .pc_next_in(pc_next_in),
        .reg_wr_en_in(reg_wr_en_in), .reg_wr_en_out(reg_wr_en_out),
        .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
        .dmem_ack_in(dmem_ack_in), .dmem_rd_data_in(dmem_rd_data_in),
        .dmem_rd_data_out(dmem_rd_data_out),
        .halted_out(halted_out), .error_out(error_out), .retired_out(retired_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          isLoad;
        logic [31:0] ld;
    } commit_t;

    logic [31:0] fetchQ[$];
    commit_t     commitQ[$];
    bit          dmemQ[$];

    int checks = 0;
    int failures = 0;

    logic [31:0] mPc;
    int          mRet;
    bit          mErr;
    bit          mHalted;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic bit isLegal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b1110011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111 || o == 7'b1100111 ||
               o == 7'b0110111 || o == 7'b0010111;
    endfunction

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (nrst) begin
            if (imem_req_out && fetchQ.size() > 0) begin
                check32("fetch_addr", imem_addr_out, fetchQ[0]);
                if (imem_ack_in) void'(fetchQ.pop_front());
            end else if (imem_req_out && imem_ack_in) begin
                check32("fetch_unexpected", 32'(imem_req_out), 32'd0);
            end
            if (dmem_req_out) begin
                if (dmemQ.size() > 0) begin
                    check32("dmem_we", 32'(dmem_we_out), 32'(dmemQ[0]));
                    if (dmem_ack_in) void'(dmemQ.pop_front());
                end else begin
                    check32("dmem_unexpected", 32'(dmem_req_out), 32'd0);
                end
            end
            if (reg_wr_en_out) begin
                if (commitQ.size() > 0) begin
                    commit_t c;
                    c = commitQ.pop_front();
                    check32("commit_pc", pc_out, c.pc);
                    check32("commit_instr", instr_out, c.instr);
                    if (c.isLoad) check32("commit_ld", dmem_rd_data_out, c.ld);
                end else begin
                    check32("wr_unexpected", 32'(reg_wr_en_out), 32'd0);
                end
            end
        end
    end

    task automatic applyReset();
        nrst = 1'b0;
        imem_ack_in = 1'b0;
        dmem_ack_in = 1'b0;
        reg_wr_en_in = 1'b1;
        fetchQ.delete();
        commitQ.delete();
        dmemQ.delete();
        repeat (2) @(posedge clk);
        #1;
        check32("rst_imem_req", 32'(imem_req_out), 32'd0);
        check32("rst_dmem_req", 32'(dmem_req_out), 32'd0);
        check32("rst_wr_en", 32'(reg_wr_en_out), 32'd0);
        nrst = 1'b1;
        check32("rst_pc", pc_out, RV);
        check32("rst_instr", instr_out, NOP);
        check32("rst_ld", dmem_rd_data_out, 32'd0);
        check32("rst_retired", 32'(retired_out), 32'd0);
        check32("rst_halted", 32'(halted_out), 32'd0);
        check32("rst_error", 32'(error_out), 32'd0);
        mPc = RV;
        mRet = 0;
        mErr = 1'b0;
        mHalted = 1'b0;
    endtask

    task automatic waitImemReq();
        int n = 0;
        while (!imem_req_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!imem_req_out) check32("fetch_timeout", 32'(imem_req_out), 32'd1);
    endtask

    // Plays one instruction end to end and advances the reference model.
    task automatic applyStimulus(input logic [31:0] word, input logic [31:0] nextPc,
                                 input logic [31:0] ldData);
        logic [6:0] opc;
        bit isLoad, isStore, writes;
        int d;
        opc = word[6:0];
        isLoad = (opc == 7'b0000011);
        isStore = (opc == 7'b0100011);
        writes = !(isStore || opc == 7'b1100011);
        fetchQ.push_back(mPc);
        reg_wr_en_in = 1'b1;
        waitImemReq();
        d = $urandom_range(0, 3);
        repeat (d) begin
            dmem_ack_in = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        dmem_ack_in = 1'b0;
        imem_ack_in = 1'b1;
        imem_data_in = word;
        @(posedge clk);
        #1;
        imem_ack_in = 1'b0;
        imem_data_in = $urandom();
        if (!isLegal(opc) || opc == 7'b1110011) begin
            mHalted = 1'b1;
            mErr = (opc != 7'b1110011);
            return;
        end
        pc_next_in = nextPc;
        if (writes) commitQ.push_back('{mPc, word, isLoad, ldData});
        if (isLoad || isStore) begin
            dmemQ.push_back(isStore);
            @(posedge clk);
            #1;
            check32("dmem_req_start", 32'(dmem_req_out), 32'd1);
            d = $urandom_range(0, 3);
            repeat (d) begin
                imem_ack_in = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            imem_ack_in = 1'b0;
            dmem_ack_in = 1'b1;
            dmem_rd_data_in = ldData;
            reg_wr_en_in = writes;
            @(posedge clk);
            #1;
            dmem_ack_in = 1'b0;
            dmem_rd_data_in = $urandom();
        end else begin
            reg_wr_en_in = writes;
            @(posedge clk);
            #1;
        end
        check32("commit_wr_en", 32'(reg_wr_en_out), 32'(writes));
        @(posedge clk);
        #1;
        reg_wr_en_in = 1'b1;
        mPc = nextPc;
        mRet++;
        if (nextPc[1:0] != 2'b00) begin
            mHalted = 1'b1;
            mErr = 1'b1;
        end
    endtask

    task automatic checkOutput();
        repeat (4) @(posedge clk);
        #1;
        check32("end_halted", 32'(halted_out), 32'(mHalted));
        check32("end_error", 32'(error_out), 32'(mErr));
        check32("end_pc", pc_out, mPc);
        check32("end_retired", 32'(retired_out), 32'(mRet % (1 << CNT_W)));
        check32("end_imem_req", 32'(imem_req_out), 32'(!mHalted));
        check32("end_fetchq", 32'(fetchQ.size()), 32'(!mHalted));
        check32("end_commitq", 32'(commitQ.size()), 32'd0);
    endtask

    task automatic runEpisode(input int endKind, input int len, input bit directed);
        logic [6:0] legal[9] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
                                 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000011, 7'b0100011};
        logic [31:0] r, word, nxt;
        logic [6:0] opc;
        applyReset();
        if (directed) applyStimulus(32'h0050_0093, 32'h0000_0004, 32'd0);
        for (int i = 0; i < len && !mHalted; i++) begin
            r = $urandom();
            opc = legal[$urandom_range(0, 8)];
            word = {r[31:7], opc};
            nxt = mPc + 32'd4;
            if ((opc == 7'b1101111 || opc == 7'b1100111 || opc == 7'b1100011) && $urandom_range(0, 1) == 1)
                nxt = $urandom() & 32'h0000_fffc;
            applyStimulus(word, nxt, $urandom());
        end
        if (endKind == 0) begin
            applyStimulus(($urandom_range(0, 1) == 1) ? 32'h0010_0073 : 32'h0000_0073, 32'd0, 32'd0);
        end else if (endKind == 1) begin
            opc = 7'b1111111;
            while (isLegal(opc) || $urandom_range(0, 2) == 0) opc = 7'($urandom_range(0, 127));
            r = $urandom();
            applyStimulus({r[31:7], opc}, 32'd0, 32'd0);
        end else if (endKind == 2) begin
            r = $urandom();
            nxt = (r & 32'h0000_fffc) | 32'($urandom_range(1, 3));
            applyStimulus({r[31:7], 7'b1101111}, nxt, 32'd0);
        end else begin
            fetchQ.push_back(mPc);
            waitImemReq();
            repeat (2) @(posedge clk);
            #1;
            nrst = 1'b0;
            #1;
            check32("midfetch_req_drop", 32'(imem_req_out), 32'd0);
            checkOutputAfterMidReset();
            return;
        end
        checkOutput();
    endtask

    task automatic checkOutputAfterMidReset();
        applyReset();
        check32("midfetch_pc", pc_out, RV);
        check32("midfetch_retired", 32'(retired_out), 32'd0);
    endtask

    initial begin
        $display("[TB] core_sequencer scoreboard bench start");
        runEpisode(0, 0, 1'b1);
        runEpisode(2, 0, 1'b1);
        runEpisode(1, 0, 1'b0);
        for (int e = 0; e < 12; e++) begin
            runEpisode(e % 4, $urandom_range(5, 30), 1'b0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
